// File: rtl/collision.sv
// D2Q9 BGK collision sweep: streams every cell through a 4-stage pipeline that
// relaxes it toward a linearised equilibrium, or bounces it back if it is a wall.
module collision #(
   parameter int HPIXELS      = 205,
   parameter int VPIXELS      = 154,
   parameter int READ_LATENCY = 2,
   parameter int TAU_SHIFT    = 1,
   localparam int DEPTH       = HPIXELS * VPIXELS,
   localparam int AW          = $clog2(DEPTH)
) (
   input  logic            clk_in,
   input  logic            rst_in,
   input  logic            start_in,
   input  logic [8:0][7:0] f_in,
   input  logic            wall_in,
   output logic [AW-1:0]   rd_addr_out,
   output logic            rd_en_out,
   output logic [AW-1:0]   wr_addr_out,
   output logic [8:0][7:0] wr_data_out,
   output logic            wr_en_out,
   output logic            busy_out,
   output logic            done
);

   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
   // Direction vectors, log2 of the lattice weight (x36) and the opposite direction.
   localparam int EX  [9] = '{0, 1, 0, -1, 0, 1, -1, -1, 1};
   localparam int EY  [9] = '{0, 0, 1, 0, -1, 1, 1, -1, -1};
   localparam int WSH [9] = '{4, 2, 2, 2, 2, 0, 0, 0, 0};
   localparam int OPP [9] = '{0, 3, 4, 1, 2, 7, 8, 5, 6};

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   state_t                  r_state;
   logic                    r_rd_en, r_busy, r_done;
   logic [AW-1:0]           r_rd_addr;
   logic [READ_LATENCY-1:0] r_dly_vld;
   logic [AW-1:0]           r_dly_addr [READ_LATENCY];

   logic [8:0][7:0]         r1_f, r2_f, r3_f, r_wr_data;
   logic [11:0]             r1_rho;
   logic signed [10:0]      r1_jx, r1_jy;
   logic signed [18:0]      r2_feq36 [9];
   logic                    r1_wall, r2_wall;
   logic                    r1_vld, r2_vld, r3_vld, r_wr_en;
   logic [AW-1:0]           r1_addr, r2_addr, r3_addr, r_wr_addr;

   logic [11:0]             w_rho;
   logic signed [10:0]      w_fs [1:8];
   logic signed [10:0]      w_jx, w_jy;
   logic signed [11:0]      w_jx12, w_jy12;
   logic signed [14:0]      w_rho15;
   logic signed [11:0]      w_ej [9];
   logic signed [14:0]      w_s [9];
   logic signed [18:0]      w_feq36 [9];
   logic signed [28:0]      w_p [9];
   logic signed [28:0]      w_feq [9];
   logic signed [28:0]      w_fz [9];
   logic signed [28:0]      w_diff [9];
   logic signed [28:0]      w_new [9];
   logic [8:0][7:0]         w_res;

   genvar gi;

   // Read address/strobe delayed to line up with the BRAM data.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_dly_vld[0]  <= 1'b0;
         r_dly_addr[0] <= '0;
      end else begin
         r_dly_vld[0]  <= r_rd_en;
         r_dly_addr[0] <= r_rd_addr;
      end
   end

   for (gi = 1; gi < READ_LATENCY; gi++) begin : g_dly
      always_ff @(posedge clk_in or posedge rst_in) begin
         if (rst_in) begin
            r_dly_vld[gi]  <= 1'b0;
            r_dly_addr[gi] <= '0;
         end else begin
            r_dly_vld[gi]  <= r_dly_vld[gi-1];
            r_dly_addr[gi] <= r_dly_addr[gi-1];
         end
      end
   end

   for (gi = 1; gi < 9; gi++) begin : g_fs
      assign w_fs[gi] = $signed({3'b000, f_in[gi]});
   end

   assign w_rho = {4'h0, f_in[0]} + {4'h0, f_in[1]} + {4'h0, f_in[2]} + {4'h0, f_in[3]}
                + {4'h0, f_in[4]} + {4'h0, f_in[5]} + {4'h0, f_in[6]} + {4'h0, f_in[7]}
                + {4'h0, f_in[8]};
   assign w_jx  = w_fs[1] - w_fs[3] + w_fs[5] - w_fs[6] - w_fs[7] + w_fs[8];
   assign w_jy  = w_fs[2] - w_fs[4] + w_fs[5] + w_fs[6] - w_fs[7] - w_fs[8];

   assign w_jx12  = {r1_jx[10], r1_jx};
   assign w_jy12  = {r1_jy[10], r1_jy};
   assign w_rho15 = {3'b000, r1_rho};

   for (gi = 0; gi < 9; gi++) begin : g_dir
      assign w_ej[gi]    = ((EX[gi] > 0) ? w_jx12 : (EX[gi] < 0) ? -w_jx12 : 12'sd0)
                         + ((EY[gi] > 0) ? w_jy12 : (EY[gi] < 0) ? -w_jy12 : 12'sd0);
      assign w_s[gi]     = w_rho15 + 15'sd3 * $signed({{3{w_ej[gi][11]}}, w_ej[gi]});
      assign w_feq36[gi] = $signed({{4{w_s[gi][14]}}, w_s[gi]}) <<< WSH[gi];

      // 455/16384 approximates 1/36 with round-half-up.
      assign w_p[gi]    = $signed({{10{r2_feq36[gi][18]}}, r2_feq36[gi]}) * 29'sd455 + 29'sd8192;
      assign w_feq[gi]  = w_p[gi] >>> 14;
      assign w_fz[gi]   = $signed({21'h0, r2_f[gi]});
      assign w_diff[gi] = w_feq[gi] - w_fz[gi];
      assign w_new[gi]  = w_fz[gi] + (w_diff[gi] >>> TAU_SHIFT);
      assign w_res[gi]  = r2_wall             ? r2_f[OPP[gi]] :
                          (w_new[gi] < 29'sd0)   ? 8'd0 :
                          (w_new[gi] > 29'sd255) ? 8'd255 : w_new[gi][7:0];
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r1_f      <= '0;
         r1_rho    <= '0;
         r1_jx     <= '0;
         r1_jy     <= '0;
         r1_wall   <= 1'b0;
         r1_vld    <= 1'b0;
         r1_addr   <= '0;
         r2_f      <= '0;
         r2_feq36  <= '{default: '0};
         r2_wall   <= 1'b0;
         r2_vld    <= 1'b0;
         r2_addr   <= '0;
         r3_f      <= '0;
         r3_vld    <= 1'b0;
         r3_addr   <= '0;
         r_wr_data <= '0;
         r_wr_en   <= 1'b0;
         r_wr_addr <= '0;
      end else begin
         r1_f      <= f_in;
         r1_rho    <= w_rho;
         r1_jx     <= w_jx;
         r1_jy     <= w_jy;
         r1_wall   <= wall_in;
         r1_vld    <= r_dly_vld[READ_LATENCY-1];
         r1_addr   <= r_dly_addr[READ_LATENCY-1];
         r2_f      <= r1_f;
         r2_feq36  <= w_feq36;
         r2_wall   <= r1_wall;
         r2_vld    <= r1_vld;
         r2_addr   <= r1_addr;
         r3_f      <= w_res;
         r3_vld    <= r2_vld;
         r3_addr   <= r2_addr;
         r_wr_data <= r3_f;
         r_wr_en   <= r3_vld;
         r_wr_addr <= r3_addr;
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_state   <= S_IDLE;
         r_rd_en   <= 1'b0;
         r_rd_addr <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (start_in) begin
                  r_state   <= S_RUN;
                  r_rd_en   <= 1'b1;
                  r_rd_addr <= '0;
                  r_busy    <= 1'b1;
               end
            end
            S_RUN: begin
               if (r_rd_addr == LAST) begin
                  r_rd_en   <= 1'b0;
                  r_rd_addr <= '0;
                  r_state   <= S_DRAIN;
               end else begin
                  r_rd_addr <= r_rd_addr + 1'b1;
               end
            end
            S_DRAIN: begin
               if (r_done) begin
                  r_done  <= 1'b0;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else if (r_wr_en && r_wr_addr == LAST) begin
                  r_done <= 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign rd_addr_out = r_rd_addr;
   assign rd_en_out   = r_rd_en;
   assign wr_addr_out = r_wr_addr;
   assign wr_data_out = r_wr_data;
   assign wr_en_out   = r_wr_en;
   assign busy_out    = r_busy;
   assign done        = r_done;

endmodule

// File: tb/tb_collision.sv
// Bench for collision on a 4x3 lattice: BRAM model feeding the DUT, a queue of
// expected writes filled per sweep, and a monitor checking every DUT strobe.
module tb_collision;

   localparam int H     = 4;
   localparam int V     = 3;
   localparam int DEPTH = H * V;
   localparam int AW    = $clog2(DEPTH);
   localparam int RL    = 2;
   localparam int TAU   = 1;
   localparam int LAT   = RL + 4;

   localparam int EX [9] = '{0, 1, 0, -1, 0, 1, -1, -1, 1};
   localparam int EY [9] = '{0, 0, 1, 0, -1, 1, 1, -1, -1};
   localparam int WT [9] = '{16, 4, 4, 4, 4, 1, 1, 1, 1};
   localparam int OP [9] = '{0, 3, 4, 1, 2, 7, 8, 5, 6};

   typedef struct packed {
      logic [31:0]     addr;
      logic [8:0][7:0] data;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst_in, start_in;
   logic [8:0][7:0] f_in = '0, ram_a = '0;
   logic            wall_in = 1'b0, wall_a = 1'b0;
   logic [AW-1:0]   rd_addr_out, wr_addr_out;
   logic            rd_en_out, wr_en_out, busy_out, done;
   logic [8:0][7:0] wr_data_out;

   logic [8:0][7:0] f_mem [DEPTH];
   logic            wall_mem [DEPTH];
   exp_t            exp_q [$];

   int cyc = 0;
   int s_edge = 0;
   int rd_cnt, wr_cnt, done_cnt;
   bit armed = 1'b0;
   int n_vec = 0;
   int n_err = 0;

   collision #(.HPIXELS(H), .VPIXELS(V), .READ_LATENCY(RL), .TAU_SHIFT(TAU)) dut (
      .clk_in(clk), .rst_in(rst_in), .start_in(start_in), .f_in(f_in), .wall_in(wall_in),
      .rd_addr_out(rd_addr_out), .rd_en_out(rd_en_out), .wr_addr_out(wr_addr_out),
      .wr_data_out(wr_data_out), .wr_en_out(wr_en_out), .busy_out(busy_out), .done(done)
   );

   initial forever #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Two-cycle BRAM: memory read then output register.
   always @(posedge clk) begin
      if (rd_en_out) begin
         ram_a  <= f_mem[rd_addr_out];
         wall_a <= wall_mem[rd_addr_out];
      end
      f_in    <= ram_a;
      wall_in <= wall_a;
   end

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc - s_edge);
      end
   endtask

   function automatic logic [8:0][7:0] ref_cell(input logic [8:0][7:0] f, input logic w);
      logic [8:0][7:0] r;
      int fv [9];
      int rho, jx, jy, ej, feq, v;
      rho = 0; jx = 0; jy = 0;
      for (int i = 0; i < 9; i++) begin
         fv[i] = {24'd0, f[i]};
         rho += fv[i];
         jx  += EX[i] * fv[i];
         jy  += EY[i] * fv[i];
      end
      for (int i = 0; i < 9; i++) begin
         if (w) begin
            r[i] = f[OP[i]];
         end else begin
            ej  = EX[i] * jx + EY[i] * jy;
            feq = (WT[i] * (rho + 3 * ej) * 455 + 8192) >>> 14;
            v   = fv[i] + ((feq - fv[i]) >>> TAU);
            if (v < 0) v = 0;
            if (v > 255) v = 255;
            r[i] = 8'(v);
         end
      end
      return r;
   endfunction

   // Monitor: every DUT strobe is compared against the scoreboard.
   always @(negedge clk) begin
      int   rel;
      exp_t e;
      rel = cyc - s_edge;
      if (!rst_in) begin
         if (armed && rel >= 0 && rel <= DEPTH + LAT)
            chk("busy_high", busy_out, 1);
         if (rd_en_out) begin
            chk("rd_armed", armed, 1);
            chk("rd_addr", rd_addr_out, rd_cnt);
            chk("rd_cycle", rel, rd_cnt);
            rd_cnt++;
         end
         if (wr_en_out) begin
            chk("wr_queue", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk("wr_addr", wr_addr_out, e.addr);
               chk("wr_data", wr_data_out, e.data);
               chk("wr_cycle", rel, e.addr + LAT);
               $display("write addr %0d data %h", wr_addr_out, wr_data_out);
            end
            wr_cnt++;
         end
         if (done) begin
            chk("done_armed", armed, 1);
            chk("done_cycle", rel, DEPTH + LAT);
            chk("done_writes", wr_cnt, DEPTH);
            done_cnt++;
         end
      end
   end

   task automatic check_zero_outputs(input string tag);
      chk({tag, "_rd_en"}, rd_en_out, 0);
      chk({tag, "_rd_addr"}, rd_addr_out, 0);
      chk({tag, "_wr_en"}, wr_en_out, 0);
      chk({tag, "_wr_addr"}, wr_addr_out, 0);
      chk({tag, "_wr_data"}, wr_data_out, 0);
      chk({tag, "_busy"}, busy_out, 0);
      chk({tag, "_done"}, done, 0);
   endtask

   // mode 0 directed cells, 1 full-range random, 2 near equilibrium, 3 small values.
   task automatic run_sweep(input int mode, input bit mid_start, input bit rst_mid);
      logic [8:0][7:0] c, ed;
      logic            w;
      exp_t            e;
      int              rel;
      exp_q.delete();
      for (int k = 0; k < DEPTH; k++) begin
         w = 1'b0;
         for (int i = 0; i < 9; i++) begin
            case (mode)
               1:       c[i] = 8'($urandom_range(0, 255));
               2:       c[i] = 8'(WT[i] * 4 + int'($urandom_range(0, 6)) - 3);
               3:       c[i] = 8'($urandom_range(0, 40));
               default: c[i] = 8'(WT[i] * 4);
            endcase
         end
         if (mode != 0) w = ($urandom_range(0, 3) == 0);
         ed = c;
         if (mode == 0 && k == 0) begin
            c = '0; c[1] = 8'd36;
            ed = '0; ed[0] = 8'd8; ed[1] = 8'd26; ed[2] = 8'd2; ed[4] = 8'd2;
            ed[5] = 8'd2; ed[8] = 8'd2;
         end else if (mode == 0 && k == 1) begin
            w = 1'b1;
            c = '0; c[0] = 8'd9; c[1] = 8'd10; c[3] = 8'd20; c[5] = 8'd1; c[7] = 8'd2;
            c[2] = 8'd3; c[4] = 8'd4;
            ed = '0; ed[0] = 8'd9; ed[1] = 8'd20; ed[3] = 8'd10; ed[5] = 8'd2; ed[7] = 8'd1;
            ed[2] = 8'd4; ed[4] = 8'd3;
         end else if (mode != 0) begin
            ed = ref_cell(c, w);
         end
         f_mem[k]    = c;
         wall_mem[k] = w;
         e.addr = k;
         e.data = ed;
         exp_q.push_back(e);
      end
      @(negedge clk);
      chk("busy_before_start", busy_out, 0);
      rd_cnt = 0; wr_cnt = 0; done_cnt = 0;
      s_edge = cyc + 1;
      armed = 1'b1;
      start_in = 1'b1;
      for (int t = 0; t < 4 * DEPTH + 40; t++) begin
         @(negedge clk);
         rel = cyc - s_edge;
         start_in = mid_start && (rel == 5 || rel == DEPTH + 2);
         if (rst_mid && rel == 4 + LAT) begin
            @(posedge clk);
            #1 rst_in = 1'b1;
            #1 check_zero_outputs("rst_mid");
            exp_q.delete();
            armed = 1'b0;
            repeat (2) @(negedge clk);
            rst_in = 1'b0;
            repeat (DEPTH + 10) @(negedge clk);
            chk("rst_writes", wr_cnt, 5);
            chk("rst_no_done", done_cnt, 0);
            break;
         end
         if (rel >= DEPTH + LAT + 1) begin
            chk("busy_after_done", busy_out, 0);
            chk("done_count", done_cnt, 1);
            chk("write_count", wr_cnt, DEPTH);
            chk("read_count", rd_cnt, DEPTH);
            chk("queue_empty", exp_q.size(), 0);
            break;
         end
      end
      start_in = 1'b0;
      armed = 1'b0;
      $display("sweep mode %0d mid_start %0d rst_mid %0d: %0d writes seen",
               mode, mid_start, rst_mid, wr_cnt);
   endtask

   initial begin
      rst_in = 1'b1;
      start_in = 1'b0;
      repeat (3) @(negedge clk);
      check_zero_outputs("reset");
      rst_in = 1'b0;
      @(negedge clk);
      chk("idle_rd_en", rd_en_out, 0);
      chk("idle_wr_en", wr_en_out, 0);
      chk("idle_busy", busy_out, 0);
      chk("idle_done", done, 0);
      run_sweep(0, 1'b0, 1'b0);
      run_sweep(1, 1'b1, 1'b0);
      run_sweep(1, 1'b0, 1'b0);
      run_sweep(2, 1'b0, 1'b1);
      run_sweep(3, 1'b0, 1'b0);
      run_sweep(2, 1'b1, 1'b0);
      run_sweep(1, 1'b0, 1'b0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/collision.md
Name: collision

Overview:
BGK-style collision stage of the D2Q9 lattice update. It alternates with the streaming pass under the top-level sequencer, running on the same nine per-direction distribution BRAMs.
- Sweeps every cell once, one cell per cycle, fully pipelined.
- Reads the cell's 9 distributions and relaxes them toward a linearised equilibrium.
- Writes the result back to the same address.
- Wall cells are bounce-backed (opposite directions swapped) instead of relaxed.

Parameters:
HPIXELS, 205, lattice width in cells
VPIXELS, 154, lattice height in cells
READ_LATENCY, 2, cycles from rd_en_out/rd_addr_out to f_in/wall_in valid (BRAM plus output register)
TAU_SHIFT, 1, relaxation factor omega = 2^-TAU_SHIFT, range 0..7

Ports:
clk_in  input  1  system clock
rst_in  input  1  reset, asynchronous, active-high
start_in  input  1  begin one sweep; honoured only in IDLE
f_in  input  [8:0][7:0]  distributions of the cell read READ_LATENCY cycles earlier; index 0 rest, 1 E, 2 N, 3 W, 4 S, 5 NE, 6 NW, 7 SW, 8 SE; unsigned
wall_in  input  1  obstacle flag for that same cell, aligned with f_in
rd_addr_out  output  $clog2(HPIXELS*VPIXELS)  cell read address, shared by all 9 BRAMs
rd_en_out  output  1  read strobe
wr_addr_out  output  $clog2(HPIXELS*VPIXELS)  cell write address
wr_data_out  output  [8:0][7:0]  post-collision distributions
wr_en_out  output  1  write strobe, all 9 BRAMs
busy_out  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse after the last write

Behaviour:
- Reset (asynchronous): every output is 0 and the state is IDLE. All pipeline valid bits and counters clear.
- Reset mid-sweep: no further writes are issued and no done pulse is produced.

State machine (IDLE, RUN, DRAIN):
- IDLE: start_in=1 moves to RUN.
- RUN:
  - Cycle c = 0..DEPTH-1 (DEPTH = HPIXELS*VPIXELS) drives rd_en_out=1 and rd_addr_out=c.
  - After the read at DEPTH-1, the state moves to DRAIN.
- DRAIN: rd_en_out=0; waits until the last write has issued.
- done pulses 1 cycle later, then the state returns to IDLE.
- start_in outside IDLE is ignored.

Pipeline:
- The read valid and address are delayed by READ_LATENCY, then pass through 3 compute stages and 1 output register.
- The write for cell k occurs at cycle k+READ_LATENCY+4, with wr_addr_out=k.
- done is asserted at cycle DEPTH+READ_LATENCY+4.
- Writes are strictly in address order, one per cycle, with no gaps.
- Read and write use separate ports (dual-port BRAM), so there is no stall.

Stage 1 (moments):
- rho = sum f_i, unsigned 12b.
- jx = f1-f3+f5-f6-f7+f8, signed 11b.
- jy = f2-f4+f5+f6-f7-f8, signed 11b.

Stage 2 (scaled equilibrium):
- e·j per direction: 0 for direction 0, ±jx or ±jy for axis directions, ±jx±jy for diagonals (signed 12b).
- s_i = rho + 3*(e·j), signed 15b.
- feq36_i = W_i*s_i, with W = 16 for direction 0, 4 for axis directions, 1 for diagonals; signed 19b.

Stage 3 (relax):
- feq_i = (feq36_i*455 + 8192) >>> 14, arithmetic shift (455/16384 ≈ 1/36, round-half-up).
- f_new_i = f_i + ((feq_i - f_i) >>> TAU_SHIFT).
- Clamp f_new_i to [0,255].

Walls:
- If wall_in=1, the output is f_out_i = f_opp(i) with no relaxation, where opp swaps 1↔3, 2↔4, 5↔7, 6↔8; f0 is unchanged.
- The wall flag travels with the data through the pipeline.

Other rules:
- Input values are used as delivered. Values outside the equilibrium range still saturate at the clamp; no error is flagged.

Test Plan:
- Equilibrium fixed point: every cell f0=64, f1..f4=16, f5..f8=4, wall=0 (rho=144, j=0) -> every write equals its input exactly.
- Single beam, TAU_SHIFT=1: f1=36, all others 0 -> f0=8, f1=26, f2=f4=2, f5=f8=2, f3=0 (clamped from -4), f6=f7=0 (clamped), f8 relaxed by the same rule as f5.
- Wall cell: f1=10, f3=20, f5=1, f7=2, f2=3, f4=4, f0=9, wall_in=1 -> f1=20, f3=10, f5=2, f7=1, f2=4, f4=3, f0=9.
- Timing, HPIXELS=4, VPIXELS=3, READ_LATENCY=2:
  - Start accepted, then 12 consecutive reads at addresses 0..11.
  - Writes at cycles 6..17 to addresses 0..11.
  - done high only at cycle 18; busy_out low the following cycle.
- Start during busy: start_in pulsed mid-sweep -> no restart, exactly DEPTH writes, a single done. A second start after done -> a full new sweep.
- Reset mid-sweep: rst_in asserted asynchronously at write 5 -> outputs 0 in the same cycle, no further wr_en_out, no done. A subsequent start runs a clean full sweep.
